// File: rtl/vga_fb_pixel_writer_pkg.sv
// vga_fb_pixel_writer_pkg: shared AXI response codes, RGB widths, VGA defaults and FSM states
package vga_fb_pixel_writer_pkg;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int CHAN_W = 4;
    localparam int COLOR_W = 3 * CHAN_W;
    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;
endpackage

// File: rtl/vga_fb_pixel_writer_beat.sv
// axi_lite_write_beat: single outstanding AXI-Lite write with independent AW/W handshakes
module axi_lite_write_beat
    import vga_fb_pixel_writer_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr,
    input  logic [AXI_DATA_WIDTH-1:0]   data,
    output logic                        xfer_done,
    output logic                        done,
    output logic [1:0]                  resp,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [1:0]                  axi_bresp,
    input  logic                        axi_bvalid,
    output logic                        axi_bready
);
    logic aw_ok, w_ok;

    always_comb begin
        aw_ok = !axi_awvalid || axi_awready;
        w_ok = !axi_wvalid || axi_wready;
        xfer_done = (axi_awvalid || axi_wvalid) && aw_ok && w_ok;
        axi_wstrb = '1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            axi_awvalid <= 1'b0;
            axi_wvalid <= 1'b0;
            axi_bready <= 1'b0;
            axi_awaddr <= '0;
            axi_wdata <= '0;
            done <= 1'b0;
            resp <= RESP_OKAY;
        end else begin
            done <= 1'b0;
            if (start) begin
                axi_awvalid <= 1'b1;
                axi_wvalid <= 1'b1;
                axi_awaddr <= addr;
                axi_wdata <= data;
            end else begin
                if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
                if (axi_wvalid && axi_wready) axi_wvalid <= 1'b0;
                if (xfer_done) axi_bready <= 1'b1;
                if (axi_bready && axi_bvalid) begin
                    axi_bready <= 1'b0;
                    done <= 1'b1;
                    resp <= axi_bresp;
                end
            end
        end
    end
endmodule

// File: rtl/vga_fb_pixel_writer.sv
// vga_fb_pixel_writer: turns (x, y, colour) pixels or a clear request into single-beat AXI-Lite framebuffer writes
module vga_fb_pixel_writer
    import vga_fb_pixel_writer_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int BASE_ADDR = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [9:0]                  pix_x,
    input  logic [9:0]                  pix_y,
    input  logic [COLOR_W-1:0]          pix_color,
    input  logic                        clear_start,
    input  logic [COLOR_W-1:0]          clear_color,
    output logic                        clear_busy,
    output logic                        clear_done,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [1:0]                  axi_bresp,
    input  logic                        axi_bvalid,
    output logic                        axi_bready,
    output logic [15:0]                 err_count,
    output logic [15:0]                 drop_count
);
    localparam int FW = AXI_ADDR_WIDTH > 32 ? AXI_ADDR_WIDTH : 32;
    localparam logic [31:0] LAST_IDX = 32'(H_VISIBLE * V_VISIBLE - 1);

    state_t state, state_next;
    logic [31:0] idx;
    logic [COLOR_W-1:0] fill_color;
    logic idle, in_range, pix_take, clear_take, launch, drop;
    logic [FW-1:0] pix_addr, clear_addr;
    logic [AXI_ADDR_WIDTH-1:0] beat_addr;
    logic [AXI_DATA_WIDTH-1:0] beat_data;
    logic xfer_done, done;
    logic [1:0] resp;

    // an active clear owns the bus; a fresh clear_start beats a waiting pixel
    always_comb begin
        idle = state == S_IDLE;
        in_range = 32'(pix_x) < 32'(H_VISIBLE) && 32'(pix_y) < 32'(V_VISIBLE);
        pix_ready = idle && !clear_busy && !clear_start;
        clear_take = idle && !clear_busy && clear_start;
        pix_take = pix_valid && pix_ready;
        launch = idle && (clear_busy || (pix_take && in_range));
        drop = pix_take && !in_range;
        pix_addr = FW'(BASE_ADDR) + FW'(pix_y) * FW'(H_VISIBLE) + FW'(pix_x);
        clear_addr = FW'(BASE_ADDR) + FW'(idx);
        beat_addr = clear_busy ? clear_addr[AXI_ADDR_WIDTH-1:0] : pix_addr[AXI_ADDR_WIDTH-1:0];
        beat_data = AXI_DATA_WIDTH'(clear_busy ? fill_color : pix_color);
        state_next = idle ? (launch ? S_XFER : S_IDLE)
                   : state == S_XFER ? (xfer_done ? S_RESP : S_XFER)
                   : (done ? S_IDLE : S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            idx <= '0;
            fill_color <= '0;
            err_count <= '0;
            drop_count <= '0;
        end else begin
            clear_done <= 1'b0;
            if (clear_take) begin
                clear_busy <= 1'b1;
                idx <= '0;
                fill_color <= clear_color;
            end
            if (drop) drop_count <= drop_count + 16'd1;
            if (done && resp != RESP_OKAY) err_count <= err_count + 16'd1;
            if (done && clear_busy) begin
                if (idx == LAST_IDX) begin
                    clear_busy <= 1'b0;
                    clear_done <= 1'b1;
                end else begin
                    idx <= idx + 32'd1;
                end
            end
        end
    end

    axi_lite_write_beat #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
    ) u_beat (
        .clk(clk),
        .reset(reset),
        .start(launch),
        .addr(beat_addr),
        .data(beat_data),
        .xfer_done(xfer_done),
        .done(done),
        .resp(resp),
        .axi_awaddr(axi_awaddr),
        .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready)
    );
endmodule

// File: doc/vga_fb_pixel_writer.md
Name: vga_fb_pixel_writer

Overview:
AXI-Lite write initiator that turns a stream of (x, y, colour) pixels into single-beat framebuffer writes through the SRAM controller. It is the write-side counterpart of the VGA pixel stream reader and replaces the fixed pattern generator as the framebuffer producer. It also provides a hardware clear mode that fills the whole visible framebuffer with one colour.

Parameters:
AXI_ADDR_WIDTH, 20, AXI address width.
AXI_DATA_WIDTH, 16, AXI data width; must be >= 12.
H_VISIBLE, 640, framebuffer width in pixels.
V_VISIBLE, 480, framebuffer height in pixels.
BASE_ADDR, 0, word address of pixel (0,0).

Ports:
clk  in  1  system clock; all logic is in this domain.
reset  in  1  synchronous, active-high reset.
pix_valid  in  1  pixel request valid.
pix_ready  out  1  pixel request accepted when pix_valid & pix_ready.
pix_x  in  10  pixel column.
pix_y  in  10  pixel row.
pix_color  in  12  colour as {red[3:0], green[3:0], blue[3:0]}.
clear_start  in  1  one-cycle request to fill the framebuffer.
clear_color  in  12  fill colour, sampled with clear_start.
clear_busy  out  1  high while a clear is in progress.
clear_done  out  1  one-cycle pulse after the last clear write's response.
axi_awaddr  out  AXI_ADDR_WIDTH  write address.
axi_awvalid  out  1  write address valid.
axi_awready  in  1  write address ready.
axi_wdata  out  AXI_DATA_WIDTH  write data.
axi_wstrb  out  AXI_DATA_WIDTH/8  write strobes; always all ones.
axi_wvalid  out  1  write data valid.
axi_wready  in  1  write data ready.
axi_bresp  in  2  write response.
axi_bvalid  in  1  write response valid.
axi_bready  out  1  write response ready.
err_count  out  16  count of responses with bresp != OKAY; wraps.
drop_count  out  16  count of out-of-range pixels dropped; wraps.

Behaviour:
- Reset values: awvalid, wvalid, bready, clear_busy, clear_done = 0; awaddr, wdata, err_count, drop_count = 0; pix_ready = 1 (state IDLE).
- States are IDLE, XFER and RESP. Only one transaction is outstanding at a time.
- IDLE: pix_ready = 1 unless clear_busy. Priority in IDLE: an active clear, then clear_start, then pixel.
- When a write is launched in IDLE at edge N:
  - awaddr = BASE_ADDR + y*H_VISIBLE + x, computed at full width, then truncated to AXI_ADDR_WIDTH.
  - wdata = zero-extended colour.
  - awvalid = wvalid = 1 from cycle N+1; go to XFER.
- XFER: AW and W are tracked independently. Each valid drops the cycle after its own handshake. awaddr and wdata are held stable while their valid is high. When both handshakes have completed (same or different cycles), go to RESP with bready = 1.
- RESP: on bvalid, bready drops next cycle; if bresp != 2'b00, err_count increments; return to IDLE. Minimum pixel-to-pixel throughput is 4 cycles.
- Out-of-range pixel (x >= H_VISIBLE or y >= V_VISIBLE): accepted with no AXI activity, drop_count increments, and the block stays in IDLE (pix_ready stays 1).
- Clear:
  - Trigger: clear_start seen in IDLE. clear_start outside IDLE is ignored.
  - Start: sets clear_busy and an internal index = 0; pix_ready is 0 throughout the clear.
  - Each clear write goes to BASE_ADDR + index with clear_color, then index increments.
  - The clear ends after index H_VISIBLE*V_VISIBLE-1 is acknowledged: clear_done pulses on the cycle clear_busy falls.
  - bresp errors during a clear count in err_count; the clear continues.
- If clear_start and pix_valid are both high in the same IDLE cycle, the clear wins and the pixel is not accepted.
- Reset mid-transaction returns the block to IDLE and drops all valids on the next edge. The SRAM controller shares the same reset, so the abandoned transaction is acceptable.

Decomposition:
- Shared package holds: AXI resp codes (OKAY=2'b00, SLVERR=2'b10), the 12-bit RGB pack/unpack widths, and the default VGA visible-area constants.
- One sub-module, axi_lite_write_beat, implements the single-write AW/W/B handshake engine (start, addr, data in; done, resp out). The pixel path and the clear path mux their address and data into it.

Test Plan:
- x=3, y=2, color 0xABC, awready=wready=bvalid=1 immediately -> exactly one write: awaddr=0x00503 (1283), wdata=0x0ABC, wstrb=2'b11; pix_ready returns high 4 cycles later.
- awready delayed 3 cycles, wready immediate -> wvalid high for 1 cycle; awvalid held with a stable address until accepted; exactly one AW, one W and one B handshake.
- bresp=2'b10 on one write followed by two OKAY writes -> err_count=1; all three writes complete.
- Pixel x=640, y=0 -> no awvalid, drop_count=1, pix_ready stays 1; the next in-range pixel writes normally.
- clear_start with clear_color 0x00F, H_VISIBLE=4, V_VISIBLE=2 -> 8 writes to addresses 0..7, each with wdata 0x000F; pix_ready=0 throughout; one clear_done pulse; clear_busy low afterwards.
- Reset asserted while in XFER with awvalid high -> next cycle awvalid=wvalid=bready=0, pix_ready=1, both counters 0.
